// File: rtl/daq_pkg.sv
// Shared record layout for the DAQ event path: field widths, the packed
// event record and its conversion to/from the flat storage word.
package daq_pkg;

  localparam int N_CH = 2;
  localparam int N_T  = 32;
  localparam int N_P  = 12;
  localparam int N_A  = 20;
  localparam int W    = N_T + N_CH * (N_P + N_A);

  // Field order of the packed struct is the storage word layout, MSB first.
  typedef struct packed {
    logic [N_T-1:0]            time_ms;
    logic [N_CH-1:0][N_P-1:0]  peak;
    logic [N_CH-1:0][N_A-1:0]  area;
  } event_t;

  function automatic logic [W-1:0] pack_event(input event_t e);
    return e;
  endfunction

  function automatic event_t unpack_event(input logic [W-1:0] w);
    return event_t'(w);
  endfunction

endpackage

// File: rtl/event_ram.sv
// Simple dual-port record store: synchronous write, asynchronous read,
// sized to map onto distributed RAM. Contents are deliberately not reset.
module event_ram #(
  parameter int W          = 96,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [W-1:0]          wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [W-1:0]          rdata
);

  logic [W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/daq_event_fifo.sv
// First-word-fall-through event buffer between DAQ and the UART printer.
// Full-buffer pushes are dropped and counted unless a pop frees a slot.
module daq_event_fifo #(
  parameter int N_CH       = daq_pkg::N_CH,
  parameter int N_T        = daq_pkg::N_T,
  parameter int N_P        = daq_pkg::N_P,
  parameter int N_A        = daq_pkg::N_A,
  parameter int DEPTH_LOG2 = 4,
  parameter int N_DROP     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_T-1:0]        time_event,
  input  logic signed [N_P-1:0] A_peak_event [N_CH],
  input  logic signed [N_A-1:0] A_area_event [N_CH],
  input  logic                  DAQ_pulse,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [N_T-1:0]        time_out,
  output logic signed [N_P-1:0] A_peak_out [N_CH],
  output logic signed [N_A-1:0] A_area_out [N_CH],
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [N_DROP-1:0]     dropped,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int W      = N_T + N_CH * (N_P + N_A);
  localparam int PEAK_LO = N_CH * N_A;
  localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2 + 1)'(1) << DEPTH_LOG2;
  localparam logic [N_DROP-1:0]   DROP_MAX = '1;

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [W-1:0]          wr_word;
  logic [W-1:0]          rd_word;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push      = DAQ_pulse && (!full || pop);
  assign drop      = DAQ_pulse && full && !pop;

  always_comb begin
    wr_word = '0;
    wr_word[W-1 -: N_T] = time_event;
    for (int i = 0; i < N_CH; i++) begin
      wr_word[PEAK_LO + i*N_P +: N_P] = A_peak_event[i];
      wr_word[i*N_A +: N_A]           = A_area_event[i];
    end
  end

  event_ram #(
    .W          (W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Stale storage must never leak out, so the head is masked when empty.
  always_comb begin
    time_out = empty ? '0 : rd_word[W-1 -: N_T];
    for (int i = 0; i < N_CH; i++) begin
      A_peak_out[i] = empty ? '0 : signed'(rd_word[PEAK_LO + i*N_P +: N_P]);
      A_area_out[i] = empty ? '0 : signed'(rd_word[i*N_A +: N_A]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Clearing takes priority over a drop landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped  <= '0;
      overflow <= 1'b0;
    end else if (clear_overflow) begin
      dropped  <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropped != DROP_MAX) dropped <= dropped + 1'b1;
    end
  end

endmodule

// File: tb/tb_daq_event_fifo.sv
// Directed bench for daq_event_fifo: single event, fill/order, overflow,
// full push+pop, random wrap with backpressure and mid-cycle reset.
module tb_daq_event_fifo;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        time_event;
  logic signed [11:0] A_peak_event [2];
  logic signed [19:0] A_area_event [2];
  logic               DAQ_pulse;
  logic               out_ready;
  logic               out_valid;
  logic [31:0]        time_out;
  logic signed [11:0] A_peak_out [2];
  logic signed [19:0] A_area_out [2];
  logic [4:0]         count;
  logic               full;
  logic               empty;
  logic [15:0]        dropped;
  logic               overflow;
  logic               clear_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  daq_event_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .time_event     (time_event),
    .A_peak_event   (A_peak_event),
    .A_area_event   (A_area_event),
    .DAQ_pulse      (DAQ_pulse),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .time_out       (time_out),
    .A_peak_out     (A_peak_out),
    .A_area_out     (A_area_out),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .dropped        (dropped),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] t, input int p, input int a);
    time_event      = t;
    A_peak_event[0] = 12'(p);
    A_peak_event[1] = 12'(-p);
    A_area_event[0] = 20'(a);
    A_area_event[1] = 20'(-a);
    DAQ_pulse       = 1'b1;
    tick();
    DAQ_pulse       = 1'b0;
  endtask

  logic [31:0] q[$];
  int  sent;
  bit  do_pop;
  bit  do_push;

  initial begin
    reset = 1'b1; time_event = '0; DAQ_pulse = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
    A_peak_event[0] = '0; A_peak_event[1] = '0; A_area_event[0] = '0; A_area_event[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_time", time_out, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;

    // Single event, held at the head with out_ready low
    time_event = 32'h0000_1234;
    A_peak_event[0] = 12'sd1000;  A_peak_event[1] = -12'sd5;
    A_area_event[0] = 20'sd20000; A_area_event[1] = -20'sd300;
    DAQ_pulse = 1'b1;
    tick();
    DAQ_pulse = 1'b0;
    chk("one_valid", out_valid, 1);
    chk("one_count", count, 1);
    chk("one_time", time_out, 32'h0000_1234);
    chk("one_peak0", A_peak_out[0], 1000);
    chk("one_peak1", A_peak_out[1], -5);
    chk("one_area0", A_area_out[0], 20000);
    chk("one_area1", A_area_out[1], -300);
    tick();
    chk("one_hold_time", time_out, 32'h0000_1234);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_empty", empty, 1);
    chk("one_valid0", out_valid, 0);
    chk("one_time0", time_out, 0);
    chk("one_peak0_0", A_peak_out[0], 0);
    chk("one_area1_0", A_area_out[1], 0);

    // Fill to 16
    for (int i = 1; i <= 16; i++) push_one(32'(i), i, -i);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_head_time", time_out, 1);
    chk("fill_head_peak0", A_peak_out[0], 1);
    chk("fill_head_peak1", A_peak_out[1], -1);
    chk("fill_head_area0", A_area_out[0], -1);

    // Overflow: three drops, head untouched
    for (int j = 0; j < 3; j++) push_one(32'(100 + j), 7, 7);
    chk("ovf_dropped", dropped, 3);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 16);
    chk("ovf_head", time_out, 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clr_dropped", dropped, 0);
    chk("clr_flag", overflow, 0);

    // Full with simultaneous push and pop
    out_ready = 1'b1;
    push_one(32'd17, 17, 17);
    out_ready = 1'b0;
    chk("fpp_count", count, 16);
    chk("fpp_dropped", dropped, 0);
    chk("fpp_head", time_out, 2);

    // Drain: 2..17 in order, drops never appear
    out_ready = 1'b1;
    for (int i = 2; i <= 17; i++) begin
      chk("drain_time", time_out, 32'(i));
      chk("drain_peak1", A_peak_out[1], -i);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", empty, 1);

    // Random traffic with backpressure, crosses pointer wrap several times
    sent = 0;
    for (int c = 0; c < 600 && (sent < 40 || q.size() != 0); c++) begin
      DAQ_pulse  = (sent < 40) && ($urandom_range(0, 2) != 0);
      time_event = $urandom;
      out_ready  = (sent >= 40) ? 1'b1 : ($urandom_range(0, 1) == 1);
      chk("rnd_count", count, q.size());
      chk("rnd_valid", out_valid, q.size() != 0);
      if (q.size() != 0) chk("rnd_head", time_out, q[0]);
      do_pop  = (q.size() != 0) && out_ready;
      do_push = DAQ_pulse && ((q.size() < 16) || do_pop);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(time_event);
      if (DAQ_pulse) sent++;
      tick();
    end
    DAQ_pulse = 1'b0;
    out_ready = 1'b0;
    chk("rnd_done_empty", empty, 1);
    chk("rnd_done_sent", sent, 40);

    // Mid-operation reset with five stored and a nonzero drop count
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    for (int i = 0; i < 17; i++) push_one(32'(200 + i), i, i);
    chk("pre_dropped", dropped, 1);
    out_ready = 1'b1;
    repeat (11) tick();
    out_ready = 1'b0;
    chk("pre_count", count, 5);
    chk("pre_head", time_out, 211);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_count", count, 0);
    chk("mid_valid", out_valid, 0);
    chk("mid_dropped", dropped, 0);
    chk("mid_overflow", overflow, 0);
    chk("mid_time", time_out, 0);
    #2;
    reset = 1'b0;
    tick();
    chk("post_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
